// File: rtl/display_timings_pkg.sv
// Shared display timing constants and helpers.
// Defaults describe 640x480@60 with 800x525 totals.
package display_timings_pkg;

  localparam int COORD_W = 10;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FRONT_DEF  = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BACK_DEF   = 48;

  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FRONT_DEF  = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BACK_DEF   = 33;

  localparam int SYNC_POL_DEF = 0;

  function automatic int sum4(
    input int a,
    input int b,
    input int c,
    input int d
  );
    return a + b + c + d;
  endfunction

  localparam int HA_BACK_PORCH = H_SYNC_DEF + H_BACK_DEF;
  localparam int VA_BACK_PORCH = V_SYNC_DEF + V_BACK_DEF;
  localparam int H_TOTAL = sum4(H_ACTIVE_DEF, H_FRONT_DEF,
                                H_SYNC_DEF, H_BACK_DEF);
  localparam int V_TOTAL = sum4(V_ACTIVE_DEF, V_FRONT_DEF,
                                V_SYNC_DEF, V_BACK_DEF);

  // true when v lies in [lo, lo+len)
  function automatic logic in_span(
    input logic [COORD_W-1:0] v,
    input int                 lo,
    input int                 len
  );
    return (int'(v) >= lo) && (int'(v) < lo + len);
  endfunction

endpackage

// File: rtl/display_timing_gen_if.sv
// Video timing bundle: scan position, enables, syncs, strobes.
// Driven by the timing generator, consumed by render logic.
interface display_timing_gen_if;
  import display_timings_pkg::*;

  logic [COORD_W-1:0] sx;
  logic [COORD_W-1:0] sy;
  logic               de;
  logic               hsync;
  logic               vsync;
  logic               line_start;
  logic               frame_start;

  modport master (
    output sx, sy, de, hsync, vsync,
    output line_start, frame_start
  );

  modport slave (
    input sx, sy, de, hsync, vsync,
    input line_start, frame_start
  );
endinterface

// File: rtl/display_timing_gen.sv
// Raster timing generator: one sx/sy counter pair with
// decode taken from the next position so all outputs align.
module display_timing_gen
  import display_timings_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FRONT  = H_FRONT_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BACK   = H_BACK_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FRONT  = V_FRONT_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BACK   = V_BACK_DEF,
  parameter int SYNC_POL = SYNC_POL_DEF
) (
  input  logic                 clk_pix,
  input  logic                 rst_n,
  input  logic                 pix_ce,
  display_timing_gen_if.master vid
);

  localparam int H_TOT = sum4(H_ACTIVE, H_FRONT,
                              H_SYNC, H_BACK);
  localparam int V_TOT = sum4(V_ACTIVE, V_FRONT,
                              V_SYNC, V_BACK);
  localparam int HA_BP = H_SYNC + H_BACK;
  localparam int VA_BP = V_SYNC + V_BACK;

  localparam logic [COORD_W-1:0] H_LAST =
    COORD_W'(H_TOT - 1);
  localparam logic [COORD_W-1:0] V_LAST =
    COORD_W'(V_TOT - 1);
  localparam logic SYNC_ON = (SYNC_POL != 0);

  logic [COORD_W-1:0] sx_q;
  logic [COORD_W-1:0] sy_q;
  logic               de_q;
  logic               hs_q;
  logic               vs_q;
  logic               ls_q;
  logic               fs_q;

  logic               wrap_h;
  logic               wrap_v;
  logic [COORD_W-1:0] nx;
  logic [COORD_W-1:0] ny;

  always_comb begin
    wrap_h = (sx_q == H_LAST);
    wrap_v = (sy_q == V_LAST);
    nx     = sx_q + COORD_W'(1);
    ny     = sy_q;
    if (wrap_h) begin
      nx = '0;
      ny = wrap_v ? '0 : sy_q + COORD_W'(1);
    end
  end

  // reset parks at the last pixel so the first enable lands on (0,0)
  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      sx_q <= H_LAST;
      sy_q <= V_LAST;
      de_q <= 1'b0;
      hs_q <= ~SYNC_ON;
      vs_q <= ~SYNC_ON;
      ls_q <= 1'b0;
      fs_q <= 1'b0;
    end else begin
      ls_q <= pix_ce && wrap_h;
      fs_q <= pix_ce && wrap_h && wrap_v;
      if (pix_ce) begin
        sx_q <= nx;
        sy_q <= ny;
        de_q <= in_span(nx, HA_BP, H_ACTIVE)
             && in_span(ny, VA_BP, V_ACTIVE);
        hs_q <= in_span(nx, 0, H_SYNC) ?
                SYNC_ON : ~SYNC_ON;
        vs_q <= in_span(ny, 0, V_SYNC) ?
                SYNC_ON : ~SYNC_ON;
      end
    end
  end

  assign vid.sx          = sx_q;
  assign vid.sy          = sy_q;
  assign vid.de          = de_q;
  assign vid.hsync       = hs_q;
  assign vid.vsync       = vs_q;
  assign vid.line_start  = ls_q;
  assign vid.frame_start = fs_q;

endmodule
